// File: rtl/life_step_if.sv
// Bundle of control and status signals between the life engine and the key/display logic.
// The master side drives load/start/run; the slave side is the engine itself.
interface life_step_if #(
   parameter int X     = 8,
   parameter int Y     = 8,
   parameter int LOG2X = 3,
   parameter int LOG2Y = 3,
   parameter int GEN_W = 16
);
   logic                   load_en;
   logic [X*Y-1:0]         load_data;
   logic                   start;
   logic                   run;
   logic                   busy;
   logic                   done;
   logic [X*Y-1:0]         grid;
   logic [GEN_W-1:0]       gen_count;
   logic [LOG2X+LOG2Y:0]   pop_count;
   logic                   stable;
   logic                   extinct;

   modport master (
      output load_en, load_data, start, run,
      input  busy, done, grid, gen_count, pop_count, stable, extinct
   );

   modport slave (
      input  load_en, load_data, start, run,
      output busy, done, grid, gen_count, pop_count, stable, extinct
   );
endinterface

// File: rtl/life_step_engine.sv
// Serial Game-of-Life engine: computes one generation per request, one cell per clock,
// scanning the live grid into a separate next buffer and committing it in one cycle.
//
// state    | meaning
// S_IDLE   | waiting; accepts load, start or run
// S_SCAN   | evaluating cell (x_q, y_q) from grid_q into next_q
// S_COMMIT | next_q becomes grid_q, status flags and counters update
module life_step_engine #(
   parameter int         X            = 8,
   parameter int         Y            = 8,
   parameter int         LOG2X        = 3,
   parameter int         LOG2Y        = 3,
   parameter bit         WRAP         = 1'b1,
   parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
   parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
   parameter int         GEN_W        = 16
) (
   input  logic          clk,
   input  logic          reset,
   life_step_if.slave    bus
);

   localparam int N     = X * Y;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int PW    = LOG2X + LOG2Y + 1;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     grid_q, grid_d;
   logic [N-1:0]     next_q, next_d;
   logic [LOG2X-1:0] x_q, x_d;
   logic [LOG2Y-1:0] y_q, y_d;
   logic [PW-1:0]    pop_acc_q, pop_acc_d;
   logic [PW-1:0]    pop_q, pop_d;
   logic [GEN_W-1:0] gen_q, gen_d;
   logic             stable_q, stable_d;
   logic             extinct_q, extinct_d;
   logic             done_q, done_d;

   logic [IDX_W-1:0] cur_idx;
   logic [3:0]       nb_cnt;
   logic             cur_live;
   logic             new_bit;

   // Off-grid neighbours either wrap to the opposite edge or read as dead.
   function automatic logic [3:0] count_nb(input logic [N-1:0] g, input int cx, input int cy);
      logic [3:0] c;
      logic       ok;
      int         nx, ny;
      c = '0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            if (!(dx == 0 && dy == 0)) begin
               nx = cx + dx;
               ny = cy + dy;
               ok = 1'b1;
               if (nx < 0) begin
                  nx = X - 1;
                  ok = WRAP;
               end else if (nx >= X) begin
                  nx = 0;
                  ok = WRAP;
               end
               if (ny < 0) begin
                  ny = Y - 1;
                  ok = ok & WRAP;
               end else if (ny >= Y) begin
                  ny = 0;
                  ok = ok & WRAP;
               end
               if (ok) c = c + {3'b000, g[IDX_W'(ny * X + nx)]};
            end
         end
      end
      return c;
   endfunction

   always_comb begin
      cur_idx  = IDX_W'(int'(y_q) * X + int'(x_q));
      cur_live = grid_q[cur_idx];
      nb_cnt   = count_nb(grid_q, int'(x_q), int'(y_q));
      new_bit  = cur_live ? SURVIVE_MASK[nb_cnt] : BIRTH_MASK[nb_cnt];
   end

   always_comb begin
      state_d   = state_q;
      grid_d    = grid_q;
      next_d    = next_q;
      x_d       = x_q;
      y_d       = y_q;
      pop_acc_d = pop_acc_q;
      pop_d     = pop_q;
      gen_d     = gen_q;
      stable_d  = stable_q;
      extinct_d = extinct_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.load_en) begin
               grid_d    = bus.load_data;
               gen_d     = '0;
               pop_d     = '0;
               stable_d  = 1'b0;
               extinct_d = 1'b0;
            end else if (bus.start || (bus.run && !stable_q)) begin
               state_d   = S_SCAN;
               x_d       = '0;
               y_d       = '0;
               pop_acc_d = '0;
            end
         end
         S_SCAN: begin
            next_d[cur_idx] = new_bit;
            pop_acc_d       = pop_acc_q + PW'(new_bit);
            if (x_q == LOG2X'(X - 1)) begin
               x_d = '0;
               if (y_q == LOG2Y'(Y - 1)) state_d = S_COMMIT;
               else                      y_d     = y_q + LOG2Y'(1);
            end else begin
               x_d = x_q + LOG2X'(1);
            end
         end
         S_COMMIT: begin
            stable_d  = (next_q == grid_q);
            grid_d    = next_q;
            pop_d     = pop_acc_q;
            extinct_d = (pop_acc_q == '0);
            gen_d     = gen_q + GEN_W'(1);
            done_d    = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         grid_q    <= '0;
         next_q    <= '0;
         x_q       <= '0;
         y_q       <= '0;
         pop_acc_q <= '0;
         pop_q     <= '0;
         gen_q     <= '0;
         stable_q  <= 1'b0;
         extinct_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         grid_q    <= grid_d;
         next_q    <= next_d;
         x_q       <= x_d;
         y_q       <= y_d;
         pop_acc_q <= pop_acc_d;
         pop_q     <= pop_d;
         gen_q     <= gen_d;
         stable_q  <= stable_d;
         extinct_q <= extinct_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = done_q;
   assign bus.grid      = grid_q;
   assign bus.gen_count = gen_q;
   assign bus.pop_count = pop_q;
   assign bus.stable    = stable_q;
   assign bus.extinct   = extinct_q;

endmodule
